sm_alu_seq: RTL and testbench

- Multicycle, parametrised sign-magnitude ALU. Successor of the combinational 9-bit ALU in the multicycle CPU datapath.
- Operands are {sign, MAG_W-bit magnitude}.
- Supports ADD, SUB, popcount-driven SLL/SRL, and a new iterative shift-add MUL.
- Uses a start/busy/done handshake so the control FSM can stall on variable-latency ops. Adds overflow and illegal-opcode flags.

---
 rtl/sm_alu_pkg.sv | 19 +
 rtl/sm_alu_seq_if.sv | 17 +
 rtl/sm_popcount.sv | 15 +
 rtl/sm_alu_seq.sv | 159 +++++++++++++++
 tb/tb_sm_alu_seq.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/sm_alu_pkg.sv
// Shared opcodes, FSM state encoding and sign constants for the sign-magnitude ALU.
package sm_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b111;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b100;

    localparam logic POS = 1'b0;
    localparam logic NEG = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/sm_alu_seq_if.sv
// Start/busy/done request bus between the control FSM (master) and the ALU (slave).
interface sm_alu_seq_if #(
    parameter int MAG_W = 8
);
    logic             start;
    logic [2:0]       op;
    logic [MAG_W:0]   a;
    logic [MAG_W:0]   b;
    logic             busy;
    logic             done;
    logic [MAG_W:0]   result;
    logic             ovf;
    logic             err;

    modport master (output start, op, a, b, input busy, done, result, ovf, err);
    modport slave  (input start, op, a, b, output busy, done, result, ovf, err);
endinterface

// File: rtl/sm_popcount.sv
// Combinational count of set bits in a MAG_W-bit vector; zero latency, no handshake.
module sm_popcount #(
    parameter int MAG_W = 8,
    parameter int CNT_W = $clog2(MAG_W + 1)
) (
    input  logic [MAG_W-1:0] i_vec,
    output logic [CNT_W-1:0] o_cnt
);
    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < MAG_W; i++) begin
            o_cnt = o_cnt + CNT_W'(i_vec[i]);
        end
    end
endmodule

// File: rtl/sm_alu_seq.sv
// Multicycle sign-magnitude ALU: ADD/SUB 1 cycle, SLL/SRL max(popcount(b),1), MUL MAG_W cycles.
// start is only sampled in IDLE; define SM_ALU_SAT_EN to saturate overflowing magnitudes.
module sm_alu_seq
    import sm_alu_pkg::*;
#(
    parameter int MAG_W = 8,
    parameter int CNT_W = $clog2(MAG_W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    sm_alu_seq_if.slave   bus
);
    state_t             r_state, w_state_nxt;
    logic [2:0]         r_op;
    logic               r_sa, r_sb;
    logic [MAG_W-1:0]   r_ma, r_mb;
    logic [CNT_W-1:0]   r_pc, r_cnt;
    logic [MAG_W-1:0]   r_sh, r_mplier;
    logic [2*MAG_W-1:0] r_acc, r_mcand;
    logic [MAG_W:0]     r_result;
    logic               r_ovf, r_err;

    logic [CNT_W-1:0]   w_pc, w_cnt_inc, w_target;
    logic               w_last, w_accept;
    logic [MAG_W-1:0]   w_sh_nxt, w_mag;
    logic [2*MAG_W-1:0] w_acc_nxt;
    logic [MAG_W:0]     w_sum;
    logic               w_sb_eff, w_sign, w_ovf, w_err;

    sm_popcount #(.MAG_W(MAG_W), .CNT_W(CNT_W)) u_popcount (
        .i_vec (bus.b[MAG_W-1:0]),
        .o_cnt (w_pc)
    );

    assign w_accept  = (r_state == IDLE) && bus.start;
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_target = CNT_W'(1);
        case (r_op)
            OP_SLL, OP_SRL: w_target = (r_pc == '0) ? CNT_W'(1) : r_pc;
            OP_MUL:         w_target = CNT_W'(MAG_W);
            default:        w_target = CNT_W'(1);
        endcase
    end
    assign w_last = (w_cnt_inc == w_target);

    // Per-cycle steps: a zero popcount leaves the shifter untouched (pass-through of A).
    always_comb begin
        w_sh_nxt = r_sh;
        if (r_pc != '0) begin
            w_sh_nxt = (r_op == OP_SLL) ? (r_sh << 1) : (r_sh >> 1);
        end
        w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    end

    always_comb begin
        w_sb_eff = r_sb ^ (r_op == OP_SUB);
        w_sum    = {1'b0, r_ma} + {1'b0, r_mb};
        w_mag    = '0;
        w_sign   = POS;
        w_ovf    = 1'b0;
        w_err    = 1'b0;
        case (r_op)
            OP_ADD, OP_SUB: begin
                if (r_sa == w_sb_eff) begin
                    w_mag  = w_sum[MAG_W-1:0];
                    w_ovf  = w_sum[MAG_W];
                    w_sign = r_sa;
                end else if (r_ma >= r_mb) begin
                    w_mag  = r_ma - r_mb;
                    w_sign = r_sa;
                end else begin
                    w_mag  = r_mb - r_ma;
                    w_sign = w_sb_eff;
                end
            end
            OP_SLL, OP_SRL: begin
                w_mag  = w_sh_nxt;
                w_sign = r_sa;
            end
            OP_MUL: begin
                w_mag  = w_acc_nxt[MAG_W-1:0];
                w_ovf  = |w_acc_nxt[2*MAG_W-1:MAG_W];
                w_sign = r_sa ^ r_sb;
            end
            default: w_err = 1'b1;
        endcase
`ifdef SM_ALU_SAT_EN
        if (w_ovf) w_mag = '1;
`endif
        if (w_mag == '0) w_sign = POS;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = EXEC;
            EXEC:    if (w_last)    w_state_nxt = FIN;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_sa     <= POS;
            r_sb     <= POS;
            r_ma     <= '0;
            r_mb     <= '0;
            r_pc     <= '0;
            r_cnt    <= '0;
            r_sh     <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_op     <= bus.op;
            r_sa     <= bus.a[MAG_W];
            r_sb     <= bus.b[MAG_W];
            r_ma     <= bus.a[MAG_W-1:0];
            r_mb     <= bus.b[MAG_W-1:0];
            r_pc     <= w_pc;
            r_cnt    <= '0;
            r_sh     <= bus.a[MAG_W-1:0];
            r_mplier <= bus.b[MAG_W-1:0];
            r_acc    <= '0;
            r_mcand  <= {{MAG_W{1'b0}}, bus.a[MAG_W-1:0]};
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else if (r_state == EXEC) begin
            r_cnt    <= w_cnt_inc;
            r_sh     <= w_sh_nxt;
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (w_last) begin
                r_result <= w_err ? '0 : {w_sign, w_mag};
                r_ovf    <= w_ovf;
                r_err    <= w_err;
            end
        end
    end

    assign bus.busy   = (r_state == EXEC);
    assign bus.done   = (r_state == FIN);
    assign bus.result = r_result;
    assign bus.ovf    = r_ovf;
    assign bus.err    = r_err;
endmodule

// File: tb/tb_sm_alu_seq.sv
// Randomised and directed check of sm_alu_seq against a signed-integer reference model.
`timescale 1ns/1ps
module tb_sm_alu_seq;
    localparam int MAG_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    sm_alu_seq_if #(.MAG_W(MAG_W)) bus ();

    sm_alu_seq #(.MAG_W(MAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: operands as signed integers, plain arithmetic, then fold back into sign-magnitude.
    task automatic model(input logic [2:0] op, input logic [8:0] a, input logic [8:0] b,
                         output logic [8:0] res, output logic ovf, output logic err, output int lat);
        int va, vb, r, mag, ma, mb, pc;
        logic sgn;
        ma  = int'(a[7:0]);
        mb  = int'(b[7:0]);
        va  = a[8] ? -ma : ma;
        vb  = b[8] ? -mb : mb;
        pc  = $countones(b[7:0]);
        ovf = 1'b0;
        err = 1'b0;
        sgn = 1'b0;
        mag = 0;
        lat = 1;
        case (op)
            3'b010, 3'b011: begin
                r   = (op == 3'b010) ? va + vb : va - vb;
                sgn = (r < 0);
                mag = (r < 0) ? -r : r;
            end
            3'b111, 3'b110: begin
                lat = (pc == 0) ? 1 : pc;
                mag = (op == 3'b111) ? ((ma << pc) % 256) : (ma >> pc);
                sgn = a[8];
            end
            3'b100: begin
                lat = MAG_W;
                mag = ma * mb;
                sgn = a[8] ^ b[8];
            end
            default: err = 1'b1;
        endcase
        if (op != 3'b110 && op != 3'b111 && mag > 255) begin
            ovf = 1'b1;
`ifdef SM_ALU_SAT_EN
            mag = 255;
`else
            mag = mag % 256;
`endif
        end
        if (mag == 0) sgn = 1'b0;
        res = err ? 9'h000 : {sgn, mag[7:0]};
    endtask

    // Issue one op, count busy cycles until done, compare against the model.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [8:0] a,
                          input logic [8:0] b, input bit poke,
                          output logic [8:0] got_res, output logic got_ovf, output int got_lat);
        logic [8:0] e_res;
        logic e_ovf, e_err;
        int e_lat, n, idle_busy;
        model(op, a, b, e_res, e_ovf, e_err, e_lat);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 40) begin
            if (bus.busy) n++;
            if (poke && n == 3) begin
                bus.start = 1'b1; bus.op = 3'b010; bus.a = 9'h0FF; bus.b = 9'h0FF;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, ".done_seen"}, 32'(bus.done), 32'd1);
        check({tag, ".lat"},       32'(n),        32'(e_lat));
        check({tag, ".result"},    32'(bus.result), 32'(e_res));
        check({tag, ".ovf"},       32'(bus.ovf),  32'(e_ovf));
        check({tag, ".err"},       32'(bus.err),  32'(e_err));
        got_res = bus.result;
        got_ovf = bus.ovf;
        got_lat = n;
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        if (poke) begin
            idle_busy = 0;
            repeat (3) begin
                idle_busy += int'(bus.busy) + int'(bus.done);
                @(negedge clk);
            end
            check({tag, ".no_queued_op"}, 32'(idle_busy), 32'd0);
            check({tag, ".held_result"}, 32'(bus.result), 32'(e_res));
        end
    endtask

    initial begin
        logic [8:0] r;
        logic o;
        int l;
        bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        check("rst.busy",   32'(bus.busy),   32'd0);
        check("rst.done",   32'(bus.done),   32'd0);
        check("rst.result", 32'(bus.result), 32'd0);
        check("rst.ovf",    32'(bus.ovf),    32'd0);
        check("rst.err",    32'(bus.err),    32'd0);
        rst = 1'b0;

        run_op("add_mixed", 3'b010, 9'h005, 9'h109, 1'b0, r, o, l);
        check("add_mixed.const", 32'(r), 32'h104);
        run_op("sub_tie", 3'b011, 9'h103, 9'h103, 1'b0, r, o, l);
        check("sub_tie.const", 32'(r), 32'h000);
        run_op("add_ovf", 3'b010, 9'd200, 9'd100, 1'b0, r, o, l);
`ifdef SM_ALU_SAT_EN
        check("add_ovf.const", 32'(r), 32'h0FF);
`else
        check("add_ovf.const", 32'(r), 32'h02C);
`endif
        check("add_ovf.flag", 32'(o), 32'd1);
        run_op("sll_pc3", 3'b111, 9'h003, 9'h007, 1'b0, r, o, l);
        check("sll_pc3.const", 32'(r), 32'h018);
        check("sll_pc3.busy", 32'(l), 32'd3);
        run_op("srl_pc0", 3'b110, 9'h180, 9'h000, 1'b0, r, o, l);
        check("srl_pc0.const", 32'(r), 32'h180);
        check("srl_pc0.busy", 32'(l), 32'd1);
        run_op("mul_ovf", 3'b100, 9'd20, 9'h10D, 1'b0, r, o, l);
`ifdef SM_ALU_SAT_EN
        check("mul_ovf.const", 32'(r), 32'h1FF);
`else
        check("mul_ovf.const", 32'(r), 32'h104);
`endif
        check("mul_ovf.busy", 32'(l), 32'd8);
        run_op("mul_negneg", 3'b100, 9'h10C, 9'h10A, 1'b0, r, o, l);
        check("mul_negneg.const", 32'(r), 32'h078);
        run_op("illegal", 3'b001, 9'h055, 9'h0AA, 1'b0, r, o, l);
        check("illegal.const", 32'(r), 32'h000);
        run_op("mul_poke", 3'b100, 9'h10B, 9'h006, 1'b1, r, o, l);

        // Abort a multiply after four EXEC cycles.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b100; bus.a = 9'h00F; bus.b = 9'h00F;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort.busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort.busy",   32'(bus.busy),   32'd0);
        check("abort.done",   32'(bus.done),   32'd0);
        check("abort.result", 32'(bus.result), 32'd0);
        check("abort.ovf",    32'(bus.ovf),    32'd0);
        check("abort.err",    32'(bus.err),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_abort_add", 3'b010, 9'h011, 9'h022, 1'b0, r, o, l);

        for (int i = 0; i < 150; i++) begin
            logic [2:0] rop;
            logic [8:0] ra, rb;
            rop = 3'($urandom_range(0, 7));
            ra  = 9'($urandom);
            rb  = 9'($urandom);
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 1'b0, r, o, l);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
